// File: rtl/unpack_s3_ctrl_pkg.sv
// Shared definitions for the base-3 byte unpacker: FSM state type,
// the descending powers of three used by the digit extraction, and
// the packed-range limit.
package unpack_s3_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int TRIT_W  = 2;
   localparam int N_TRITS = 5;

   // Largest byte that encodes five valid trits (3^5 - 1)
   localparam logic [7:0] MAX_PACKED = 8'd242;

   // Powers of three for digits 4..1, most significant digit first
   localparam logic [3:0][7:0] POW = {8'd81, 8'd27, 8'd9, 8'd3};

   // Power of three subtracted while extracting digit k (k = 4..1)
   function automatic logic [7:0] pow_of(input logic [2:0] k);
      logic [7:0] p;
      p = 8'd0;
      case (k)
         3'd4:    p = POW[3];
         3'd3:    p = POW[2];
         3'd2:    p = POW[1];
         3'd1:    p = POW[0];
         default: p = 8'd0;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/unpack_s3_ctrl_sub.sv
// 8-bit subtractor with carry-out. o_carry = 1 means i_x1 >= i_y
// (no borrow), in which case o_diff is the true difference.
module sub_2i8_o8 (
   input  logic [7:0] i_x1,
   input  logic [7:0] i_y,
   output logic [7:0] o_diff,
   output logic       o_carry
);

   logic [8:0] w_full;

   // Two's-complement subtraction, carry out of bit 7 is the no-borrow flag
   always_comb begin
      w_full  = {1'b0, i_x1} + {1'b0, ~i_y} + 9'd1;
      o_diff  = w_full[7:0];
      o_carry = w_full[8];
   end

endmodule

// File: rtl/unpack_s3_ctrl.sv
// Unpacks one byte holding five base-3 digits into five 2-bit trits.
// Digits 4..1 are found by repeated subtraction of 81/27/9/3 through a
// single shared subtractor, two attempts per digit, so every byte takes
// exactly 8 SUB cycles regardless of its value. The remainder left after
// digit 1 is digit 0.
// Optional build macro UNPACK_S3_RANGE_CHK_EN adds the err output and
// flags bytes above 242 with zeroed trits instead of a decoded value.
module unpack_s3_ctrl
   import unpack_s3_ctrl_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [7:0]                  in_byte,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [N_TRITS*TRIT_W-1:0]   out_trits
`ifdef UNPACK_S3_RANGE_CHK_EN
   ,
   output logic                        err
`endif
);

   state_t      r_state;
   state_t      w_state_next;

   logic [7:0]  r_rem;
   logic [2:0]  r_k;
   logic        r_attempt;
   logic [1:0]  r_count;
   logic [5:0]  r_acc;

   logic [7:0]  w_pow;
   logic [7:0]  w_diff;
   logic        w_carry;
   logic [7:0]  w_rem_next;
   logic [1:0]  w_count_next;
   logic        w_last;

`ifdef UNPACK_S3_RANGE_CHK_EN
   logic        r_over;
`endif

   assign w_pow = pow_of(r_k);

   sub_2i8_o8 u_sub (
      .i_x1    (r_rem),
      .i_y     (w_pow),
      .o_diff  (w_diff),
      .o_carry (w_carry)
   );

   // Result of the current subtraction attempt and end-of-byte detect
   always_comb begin
      w_rem_next   = w_carry ? w_diff : r_rem;
      w_count_next = r_count + {1'b0, w_carry};
      w_last       = (r_k == 3'd1) && r_attempt;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode and input handshake
   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_next = SUB;
            end
         end
         SUB: begin
            if (w_last) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            if (out_valid && out_ready) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Datapath: load byte, step digit extraction, publish trits on entry to DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rem     <= 8'd0;
         r_k       <= 3'd4;
         r_count   <= 2'd0;
         r_attempt <= 1'b0;
         r_acc     <= 6'd0;
         out_valid <= 1'b0;
         out_trits <= '0;
`ifdef UNPACK_S3_RANGE_CHK_EN
         r_over    <= 1'b0;
         err       <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_rem     <= in_byte;
                  r_k       <= 3'd4;
                  r_attempt <= 1'b0;
                  r_count   <= 2'd0;
`ifdef UNPACK_S3_RANGE_CHK_EN
                  r_over    <= (in_byte > MAX_PACKED);
`endif
               end
            end
            SUB: begin
               r_rem <= w_rem_next;
               if (!r_attempt) begin
                  r_attempt <= 1'b1;
                  r_count   <= w_count_next;
               end else begin
                  r_attempt <= 1'b0;
                  r_count   <= 2'd0;
                  r_acc     <= {r_acc[3:0], w_count_next};
                  r_k       <= r_k - 3'd1;
                  if (w_last) begin
                     out_valid <= 1'b1;
`ifdef UNPACK_S3_RANGE_CHK_EN
                     if (r_over) begin
                        out_trits <= '0;
                        err       <= 1'b1;
                     end else begin
                        out_trits <= {r_acc, w_count_next, w_rem_next[1:0]};
                     end
`else
                     out_trits <= {r_acc, w_count_next, w_rem_next[1:0]};
`endif
                  end
               end
            end
            DONE: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
`ifdef UNPACK_S3_RANGE_CHK_EN
                  err       <= 1'b0;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_unpack_s3_ctrl.sv
// Bench for unpack_s3_ctrl. Stimulus pushes the expected trits of each
// accepted byte into a queue; an independent monitor pops and compares
// whenever an output handshake happens, and also checks latency, hold
// stability and in_ready while output is pending.
// Honours UNPACK_S3_RANGE_CHK_EN for the err port and out-of-range bytes.
module tb_unpack_s3_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_byte;
   logic       out_valid;
   logic       out_ready;
   logic [9:0] out_trits;
`ifdef UNPACK_S3_RANGE_CHK_EN
   logic       err;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit readyRandom = 1'b0;

   typedef struct {
      logic [9:0] trits;
      logic       errBit;
   } exp_t;

   exp_t expQ[$];
   int   acceptQ[$];

   unpack_s3_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_byte   (in_byte),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_trits (out_trits)
`ifdef UNPACK_S3_RANGE_CHK_EN
      ,
      .err       (err)
`endif
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Edge counter used for latency measurement
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Reference: greedy base-3 digits, at most two of each power, remainder low bits
   function automatic exp_t model(input logic [7:0] b);
      exp_t e;
      int   rem;
      int   t;
      int   pw [4];
      pw       = '{81, 27, 9, 3};
      rem      = int'(b);
      e.trits  = '0;
      e.errBit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         t = rem / pw[i];
         if (t > 2) t = 2;
         rem = rem - t * pw[i];
         e.trits[9-2*i -: 2] = t[1:0];
      end
      e.trits[1:0] = rem[1:0];
`ifdef UNPACK_S3_RANGE_CHK_EN
      if (b > 8'd242) begin
         e.trits  = '0;
         e.errBit = 1'b1;
      end
`endif
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic reportTimeout(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: bounded wait expired (cycle %0d)", name, cyc);
   endtask

   // Advance to just after the next rising edge; refresh random out_ready
   task automatic tick();
      @(posedge clk);
      #1;
      if (readyRandom) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic pushAccept(input logic [7:0] b);
      expQ.push_back(model(b));
      acceptQ.push_back(cyc + 1);
   endtask

   // Offer one byte and hold it until the DUT accepts
   task automatic applyStimulus(input logic [7:0] b);
      bit got;
      got = 1'b0;
      tick();
      in_byte  = b;
      in_valid = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1'b1;
            break;
         end
         tick();
      end
      if (got) pushAccept(b);
      else     reportTimeout("accept_timeout");
      tick();
      in_valid = 1'b0;
   endtask

   task automatic waitDrain();
      bit done;
      done = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (expQ.size() == 0 && acceptQ.size() == 0 && !out_valid) begin
            done = 1'b1;
            break;
         end
         tick();
      end
      if (!done) reportTimeout("drain_timeout");
   endtask

   // Monitor: latency on rise, hold while stalled, compare on handshake
   initial begin
      logic       prevValid;
      logic       prevHs;
      logic [9:0] prevTrits;
      int         a;
      exp_t       e;
      prevValid = 1'b0;
      prevHs    = 1'b0;
      prevTrits = '0;
      forever begin
         @(negedge clk);
         if (rst === 1'b0) begin
            if (out_valid && !prevValid) begin
               if (acceptQ.size() == 0) begin
                  checkOutput("spurious_valid", out_valid, 0);
               end else begin
                  a = acceptQ.pop_front();
                  checkOutput("latency", cyc - a, 8);
               end
            end
            if (out_valid && prevValid && !prevHs)
               checkOutput("hold_trits", out_trits, prevTrits);
            if (out_valid)
               checkOutput("in_ready_busy", in_ready, 0);
            if (out_valid && out_ready) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpected_out", out_valid, 0);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("trits", out_trits, e.trits);
`ifdef UNPACK_S3_RANGE_CHK_EN
                  checkOutput("err", err, e.errBit);
`endif
               end
            end
         end
         prevValid = (out_valid === 1'b1);
         prevTrits = out_trits;
         prevHs    = (out_valid === 1'b1) && (out_ready === 1'b1) && (rst === 1'b0);
      end
   end

   // Watchdog so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: run did not complete, errors so far %0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence
   initial begin
      bit         got;
      logic [7:0] rb;
      exp_t       ex;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_byte   = 8'h00;
      out_ready = 1'b0;

      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_in_ready",  in_ready,  1);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_out_trits", out_trits, 0);
`ifdef UNPACK_S3_RANGE_CHK_EN
      checkOutput("reset_err", err, 0);
`endif

      // Directed values, consumer always ready
      tick();
      out_ready = 1'b1;
      applyStimulus(8'h00);
      applyStimulus(8'hF2);
      applyStimulus(8'd100);
      applyStimulus(8'hFF);
      waitDrain();

      // Consumer stall for 5 cycles with a second byte offered meanwhile
      tick();
      out_ready = 1'b0;
      applyStimulus(8'd173);
      got = 1'b0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (out_valid) begin
            got = 1'b1;
            break;
         end
         tick();
      end
      if (!got) reportTimeout("stall_valid_timeout");
      ex = model(8'd173);
      tick();
      in_byte  = 8'h55;
      in_valid = 1'b1;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         checkOutput("stall_valid",    out_valid, 1);
         checkOutput("stall_trits",    out_trits, ex.trits);
         checkOutput("stall_in_ready", in_ready,  0);
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("release_in_ready_before", in_ready, 0);
      tick();
      @(negedge clk);
      checkOutput("release_accept",    in_ready,  1);
      checkOutput("release_out_valid", out_valid, 0);
      if (in_ready) pushAccept(8'h55);
      tick();
      in_valid = 1'b0;
      waitDrain();

      // Reset on the 4th SUB edge discards the byte in flight
      applyStimulus(8'hF2);
      tick();
      tick();
      tick();
      rst = 1'b1;
      expQ.delete();
      acceptQ.delete();
      tick();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abort_in_ready",  in_ready,  1);
      checkOutput("abort_out_valid", out_valid, 0);
      checkOutput("abort_out_trits", out_trits, 0);
      repeat (12) tick();
      applyStimulus(8'h01);
      waitDrain();

      // Random bytes with random consumer back-pressure and idle gaps
      readyRandom = 1'b1;
      for (int n = 0; n < 24; n++) begin
         rb = 8'($urandom_range(0, 255));
         applyStimulus(rb);
         repeat ($urandom_range(0, 3)) tick();
      end
      readyRandom = 1'b0;
      tick();
      out_ready = 1'b1;
      waitDrain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
